// File: rtl/seq_alu_param.sv
// -----------------------------------------------------------------------------
// seq_alu_param
//   Parametrised sequential arithmetic engine. It does add and subtract
//   (one cycle), signed radix-4 Booth multiply (WIDTH/2 cycles) and
//   unsigned non-restoring division (WIDTH cycles plus one correction cycle).
//   Both operands are loaded in parallel. The full 2*WIDTH result is
//   presented in parallel.
//
// Handshake:
//   start is sampled only while idle (busy=0). The edge that samples start=1
//   accepts the request and captures op_code, operand_a and operand_b.
//   busy stays high from that edge until DONE is left. done pulses for one
//   cycle when the results are valid. Results hold until the next accepted
//   start. A start seen while busy is ignored.
//
// Parameters:
//   WIDTH  operand width. It must be even and at least 4.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   reset        asynchronous reset, active low
//   start        request strobe
//   op_code      00 add, 01 sub, 10 signed mul, 11 unsigned div
//   operand_a    augend / minuend / multiplicand / dividend
//   operand_b    addend / subtrahend / multiplier / divisor
//   busy         high while an operation is in flight
//   done         one-cycle pulse; results valid
//   result_hi    sign extension / upper product / remainder
//   result_lo    sum or difference / lower product / quotient
//   overflow     signed overflow of add/sub
//   div_by_zero  divide issued with operand_b == 0
//
// Optional build macro SEQ_ALU_DEBUG_EN adds three outputs:
//   dbg_state  current FSM state
//   dbg_count  iteration counter
//   dbg_acc    accumulator or partial remainder
// -----------------------------------------------------------------------------
module seq_alu_param #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op_code,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result_hi,
  output logic [WIDTH-1:0]   result_lo,
  output logic               overflow,
  output logic               div_by_zero
`ifdef SEQ_ALU_DEBUG_EN
  ,
  output logic [2:0]             dbg_state,
  output logic [$clog2(WIDTH):0] dbg_count,
  output logic [WIDTH:0]         dbg_acc
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  // The accumulator needs two guard bits. Booth partial sums reach +/-2^WIDTH.
  // A doubled partial remainder reaches +/-2^(WIDTH+1).
  localparam int AW = WIDTH + 2;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH / 2 - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDSUB = 3'd1,
    S_MUL    = 3'd2,
    S_DIV    = 3'd3,
    S_CORR   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               sub_q;     // add/sub selector captured at accept
  logic [WIDTH-1:0]   m_q;       // addend A, multiplicand or divisor
  logic [WIDTH-1:0]   q_q;       // addend B, multiplier or dividend/quotient
  logic               qm1_q;     // Booth Q[-1]
  logic [AW-1:0]      acc_q;
  logic [WIDTH-1:0]   res_hi_q, res_lo_q;
  logic               ovf_q, dbz_q;

  // ---------------- datapath combinational helpers ----------------
  logic [WIDTH:0]     as_a, as_b, as_sum;
  logic [AW-1:0]      m_ext, d_ext, booth_sel, mul_sum, mul_acc_n;
  logic [WIDTH-1:0]   mul_q_n;
  logic [AW-1:0]      div_shift, div_p_n, corr_p;
  logic [WIDTH-1:0]   div_q_n;

  always_comb begin
    as_a   = {m_q[WIDTH-1], m_q};
    as_b   = {q_q[WIDTH-1], q_q};
    as_sum = sub_q ? (as_a - as_b) : (as_a + as_b);

    m_ext  = {{2{m_q[WIDTH-1]}}, m_q};
    d_ext  = {2'b00, m_q};

    case ({q_q[1:0], qm1_q})
      3'b001, 3'b010: booth_sel = m_ext;
      3'b011:         booth_sel = m_ext << 1;
      3'b100:         booth_sel = -(m_ext << 1);
      3'b101, 3'b110: booth_sel = -m_ext;
      default:        booth_sel = '0;
    endcase
    mul_sum   = acc_q + booth_sel;
    // Arithmetic shift right by 2 of the whole {acc, Q, Q[-1]} chain.
    mul_acc_n = {{2{mul_sum[AW-1]}}, mul_sum[AW-1:2]};
    mul_q_n   = {mul_sum[1:0], q_q[WIDTH-1:2]};

    // Non-restoring step. The sign of the current remainder picks add or sub.
    // The sign of the new remainder gives the quotient bit.
    div_shift = {acc_q[AW-2:0], q_q[WIDTH-1]};
    div_p_n   = acc_q[AW-1] ? (div_shift + d_ext) : (div_shift - d_ext);
    div_q_n   = {q_q[WIDTH-2:0], ~div_p_n[AW-1]};

    corr_p    = acc_q[AW-1] ? (acc_q + d_ext) : acc_q;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op_code)
            2'b10:   state_d = S_MUL;
            2'b11:   state_d = (operand_b == '0) ? S_DONE : S_DIV;
            default: state_d = S_ADDSUB;
          endcase
        end
      end
      S_ADDSUB: state_d = S_DONE;
      S_MUL:    if (cnt_q == MUL_LAST) state_d = S_DONE;
      S_DIV:    if (cnt_q == DIV_LAST) state_d = S_CORR;
      S_CORR:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    result_hi   = res_hi_q;
    result_lo   = res_lo_q;
    overflow    = ovf_q;
    div_by_zero = dbz_q;
`ifdef SEQ_ALU_DEBUG_EN
    dbg_state   = state_q;
    dbg_count   = cnt_q;
    dbg_acc     = acc_q[WIDTH:0];
`endif
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      sub_q    <= 1'b0;
      m_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      acc_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sub_q <= op_code[0];
            cnt_q <= '0;
            acc_q <= '0;
            qm1_q <= 1'b0;
            ovf_q <= 1'b0;
            dbz_q <= 1'b0;
            if (op_code == 2'b11) begin
              m_q <= operand_b;
              q_q <= operand_a;
              // A zero divisor completes right away with a fixed result.
              if (operand_b == '0) begin
                dbz_q    <= 1'b1;
                res_lo_q <= '1;
                res_hi_q <= operand_a;
              end
            end else begin
              m_q <= operand_a;
              q_q <= operand_b;
            end
          end
        end
        S_ADDSUB: begin
          res_lo_q <= as_sum[WIDTH-1:0];
          res_hi_q <= {WIDTH{as_sum[WIDTH]}};
          ovf_q    <= as_sum[WIDTH] ^ as_sum[WIDTH-1];
        end
        S_MUL: begin
          acc_q <= mul_acc_n;
          q_q   <= mul_q_n;
          qm1_q <= q_q[1];
          if (cnt_q == MUL_LAST) begin
            res_hi_q <= mul_acc_n[WIDTH-1:0];
            res_lo_q <= mul_q_n;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DIV: begin
          acc_q <= div_p_n;
          q_q   <= div_q_n;
          if (cnt_q != DIV_LAST) cnt_q <= cnt_q + CNT_W'(1);
        end
        S_CORR: begin
          acc_q    <= corr_p;
          res_hi_q <= corr_p[WIDTH-1:0];
          res_lo_q <= q_q;
        end
        default: ;
      endcase
    end
  end

endmodule
